// File: rtl/tlb_param_if.sv
// Bus bundle between the pipeline/CP0 side (master) and the joint TLB (slave).
// With TLB_MULTIHIT_EN defined the bundle also carries the tlb_multihit pulse.
interface tlb_param_if #(
  parameter int PFN_W = 20
);
  logic             stallF;
  logic             stallM;
  logic             flushM;
  logic [31:0]      inst_vaddr;
  logic             inst_en;
  logic [31:0]      data_vaddr;
  logic             mem_read_enM;
  logic             mem_write_enM;
  logic [PFN_W-1:0] inst_pfn;
  logic [PFN_W-1:0] data_pfn;
  logic             no_cache_i;
  logic             no_cache_d;
  logic             inst_tlb_refill;
  logic             inst_tlb_invalid;
  logic             data_tlb_refill;
  logic             data_tlb_invalid;
  logic             data_tlb_modify;
  logic             TLBP;
  logic             TLBR;
  logic             TLBWI;
  logic             TLBWR;
  logic [31:0]      EntryHi_in;
  logic [31:0]      PageMask_in;
  logic [31:0]      EntryLo0_in;
  logic [31:0]      EntryLo1_in;
  logic [31:0]      Index_in;
  logic [31:0]      wired_in;
  logic             wired_we;
  logic [31:0]      EntryHi_out;
  logic [31:0]      PageMask_out;
  logic [31:0]      EntryLo0_out;
  logic [31:0]      EntryLo1_out;
  logic [31:0]      Index_out;
  logic [31:0]      Random_out;
  logic [31:0]      Wired_out;
`ifdef TLB_MULTIHIT_EN
  logic             tlb_multihit;
`endif

  modport slave (
    input  stallF, stallM, flushM, inst_vaddr, inst_en, data_vaddr,
           mem_read_enM, mem_write_enM, TLBP, TLBR, TLBWI, TLBWR,
           EntryHi_in, PageMask_in, EntryLo0_in, EntryLo1_in, Index_in,
           wired_in, wired_we,
    output inst_pfn, data_pfn, no_cache_i, no_cache_d,
           inst_tlb_refill, inst_tlb_invalid,
           data_tlb_refill, data_tlb_invalid, data_tlb_modify,
           EntryHi_out, PageMask_out, EntryLo0_out, EntryLo1_out, Index_out,
           Random_out, Wired_out
`ifdef TLB_MULTIHIT_EN
    , output tlb_multihit
`endif
  );

  modport master (
    output stallF, stallM, flushM, inst_vaddr, inst_en, data_vaddr,
           mem_read_enM, mem_write_enM, TLBP, TLBR, TLBWI, TLBWR,
           EntryHi_in, PageMask_in, EntryLo0_in, EntryLo1_in, Index_in,
           wired_in, wired_we,
    input  inst_pfn, data_pfn, no_cache_i, no_cache_d,
           inst_tlb_refill, inst_tlb_invalid,
           data_tlb_refill, data_tlb_invalid, data_tlb_modify,
           EntryHi_out, PageMask_out, EntryLo0_out, EntryLo1_out, Index_out,
           Random_out, Wired_out
`ifdef TLB_MULTIHIT_EN
    , input tlb_multihit
`endif
  );
endinterface

// File: rtl/tlb_param.sv
// Parametrised joint I/D TLB with CP0 Random/Wired and TLBP/TLBR/TLBWI/TLBWR.
// Optional multi-hit detection is enabled by defining TLB_MULTIHIT_EN.
module tlb_param #(
  parameter int ENTRIES = 16,
  parameter int ASID_W  = 8,
  parameter int PFN_W   = 20
) (
  input logic         clk,
  input logic         rst,
  tlb_param_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ENTRIES - 1);

  logic [ENTRIES-1:0] valid_q, g_q, d0_q, d1_q, v0_q, v1_q;
  logic [18:0]        vpn2_q [ENTRIES];
  logic [18:0]        mask_q [ENTRIES];
  logic [ASID_W-1:0]  asid_q [ENTRIES];
  logic [PFN_W-1:0]   pfn0_q [ENTRIES];
  logic [PFN_W-1:0]   pfn1_q [ENTRIES];
  logic [2:0]         c0_q   [ENTRIES];
  logic [2:0]         c1_q   [ENTRIES];

  logic [IDX_W-1:0]   random_q, wired_q;
  logic [ASID_W-1:0]  cur_asid;
  logic [ENTRIES-1:0] m_inst, m_data, m_probe;

  assign cur_asid = bus.EntryHi_in[ASID_W-1:0];

  always_comb begin
    m_inst  = '0;
    m_data  = '0;
    m_probe = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (g_q[i] || asid_q[i] == cur_asid)) begin
        m_inst[i]  = ((bus.inst_vaddr[31:13] ^ vpn2_q[i]) & ~mask_q[i]) == '0;
        m_data[i]  = ((bus.data_vaddr[31:13] ^ vpn2_q[i]) & ~mask_q[i]) == '0;
        m_probe[i] = ((bus.EntryHi_in[31:13] ^ vpn2_q[i]) & ~mask_q[i]) == '0;
      end
    end
  end

  function automatic logic [IDX_W-1:0] or_encode(input logic [ENTRIES-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ENTRIES; i++)
      if (m[i]) r = r | IDX_W'(i);
    return r;
  endfunction

  // Lookup result registers
  logic             i_en_q, i_hit_q, i_odd_q, i_k01_q, i_k1_q;
  logic [IDX_W-1:0] i_idx_q;
  logic [19:0]      i_vpn_q;
  logic             d_live_q, d_hit_q, d_odd_q, d_k01_q, d_k1_q;
  logic [IDX_W-1:0] d_idx_q;
  logic [19:0]      d_vpn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_en_q  <= 1'b0;
      i_hit_q <= 1'b0;
      i_odd_q <= 1'b0;
      i_k01_q <= 1'b0;
      i_k1_q  <= 1'b0;
      i_idx_q <= '0;
      i_vpn_q <= '0;
    end else if (!bus.stallF) begin
      i_en_q  <= bus.inst_en;
      i_hit_q <= |m_inst;
      i_odd_q <= bus.inst_vaddr[12];
      i_k01_q <= bus.inst_vaddr[31:30] == 2'b10;
      i_k1_q  <= bus.inst_vaddr[31:29] == 3'b101;
      i_idx_q <= or_encode(m_inst);
      i_vpn_q <= bus.inst_vaddr[31:12];
    end
  end

  // d_live_q marks a real access in M; a flushed or reset stage never raises exceptions
  always_ff @(posedge clk) begin
    if (rst || bus.flushM) begin
      d_live_q <= 1'b0;
      d_hit_q  <= 1'b0;
      d_odd_q  <= 1'b0;
      d_k01_q  <= 1'b0;
      d_k1_q   <= 1'b0;
      d_idx_q  <= '0;
      d_vpn_q  <= '0;
    end else if (!bus.stallM) begin
      d_live_q <= 1'b1;
      d_hit_q  <= |m_data;
      d_odd_q  <= bus.data_vaddr[12];
      d_k01_q  <= bus.data_vaddr[31:30] == 2'b10;
      d_k1_q   <= bus.data_vaddr[31:29] == 3'b101;
      d_idx_q  <= or_encode(m_data);
      d_vpn_q  <= bus.data_vaddr[31:12];
    end
  end

  // Translation outputs
  logic [PFN_W-1:0] i_sel_pfn, d_sel_pfn;
  logic [2:0]       i_sel_c, d_sel_c;
  logic             i_sel_v, d_sel_v, d_sel_d;
  logic             i_acc, d_acc;

  always_comb begin
    i_sel_pfn = i_odd_q ? pfn1_q[i_idx_q] : pfn0_q[i_idx_q];
    i_sel_c   = i_odd_q ? c1_q[i_idx_q]   : c0_q[i_idx_q];
    i_sel_v   = i_odd_q ? v1_q[i_idx_q]   : v0_q[i_idx_q];
    d_sel_pfn = d_odd_q ? pfn1_q[d_idx_q] : pfn0_q[d_idx_q];
    d_sel_c   = d_odd_q ? c1_q[d_idx_q]   : c0_q[d_idx_q];
    d_sel_v   = d_odd_q ? v1_q[d_idx_q]   : v0_q[d_idx_q];
    d_sel_d   = d_odd_q ? d1_q[d_idx_q]   : d0_q[d_idx_q];
    i_acc     = i_en_q & ~i_k01_q;
    d_acc     = d_live_q & ~d_k01_q & (bus.mem_read_enM | bus.mem_write_enM);

    bus.inst_pfn         = i_k01_q ? PFN_W'(i_vpn_q[PFN_W-4:0]) : i_sel_pfn;
    bus.no_cache_i       = i_k01_q ? i_k1_q : (i_sel_c == 3'b010);
    bus.inst_tlb_refill  = i_acc & ~i_hit_q;
    bus.inst_tlb_invalid = i_acc & i_hit_q & ~i_sel_v;

    bus.data_pfn         = d_k01_q ? PFN_W'(d_vpn_q[PFN_W-4:0]) : d_sel_pfn;
    bus.no_cache_d       = d_k01_q ? d_k1_q : (d_sel_c == 3'b010);
    bus.data_tlb_refill  = d_acc & ~d_hit_q;
    bus.data_tlb_invalid = d_acc & d_hit_q & ~d_sel_v;
    bus.data_tlb_modify  = d_live_q & ~d_k01_q & bus.mem_write_enM & d_hit_q & d_sel_v & ~d_sel_d;
  end

  // Entry writes
  logic             we;
  logic [IDX_W-1:0] widx;
  logic [18:0]      new_mask, new_vpn2;
  logic [PFN_W-1:0] pfn_keep;
  logic             new_g;

  assign we       = bus.TLBWI | bus.TLBWR;
  assign widx     = bus.TLBWI ? bus.Index_in[IDX_W-1:0] : random_q;
  assign new_mask = bus.PageMask_in[31:13];
  assign new_vpn2 = bus.EntryHi_in[31:13] & ~new_mask;
  assign pfn_keep = ~PFN_W'({new_mask, 1'b0});
  assign new_g    = bus.EntryLo0_in[0] & bus.EntryLo1_in[0];

  always_ff @(posedge clk) begin
    if (rst)     valid_q <= '0;
    else if (we) valid_q[widx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      vpn2_q[widx] <= new_vpn2;
      mask_q[widx] <= new_mask;
      asid_q[widx] <= cur_asid;
      g_q[widx]    <= new_g;
      pfn0_q[widx] <= bus.EntryLo0_in[PFN_W+5:6] & pfn_keep;
      pfn1_q[widx] <= bus.EntryLo1_in[PFN_W+5:6] & pfn_keep;
      c0_q[widx]   <= bus.EntryLo0_in[5:3];
      c1_q[widx]   <= bus.EntryLo1_in[5:3];
      d0_q[widx]   <= bus.EntryLo0_in[2];
      d1_q[widx]   <= bus.EntryLo1_in[2];
      v0_q[widx]   <= bus.EntryLo0_in[1];
      v1_q[widx]   <= bus.EntryLo1_in[1];
    end
  end

  // Random counts down to Wired then wraps; the <= compare also pins it when Wired is top
  always_ff @(posedge clk) begin
    if (rst) begin
      random_q <= TOP_IDX;
      wired_q  <= '0;
    end else if (bus.wired_we) begin
      random_q <= TOP_IDX;
      wired_q  <= bus.wired_in[IDX_W-1:0];
    end else if (!bus.stallM) begin
      random_q <= (random_q <= wired_q) ? TOP_IDX : random_q - 1'b1;
    end
  end

  assign bus.Random_out = 32'(random_q);
  assign bus.Wired_out  = 32'(wired_q);

`ifdef TLB_MULTIHIT_EN
  logic mh_sticky_q, mh_pulse_q, dup, any_multi;

  always_comb begin
    any_multi = |(m_inst & (m_inst - 1'b1)) | |(m_data & (m_data - 1'b1)) |
                |(m_probe & (m_probe - 1'b1));
    dup = 1'b0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (IDX_W'(i) != widx && valid_q[i] &&
          (((new_vpn2 ^ vpn2_q[i]) & ~new_mask & ~mask_q[i]) == '0) &&
          (new_g || g_q[i] || asid_q[i] == cur_asid))
        dup = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mh_sticky_q <= 1'b0;
      mh_pulse_q  <= 1'b0;
    end else begin
      if (any_multi) mh_sticky_q <= 1'b1;
      mh_pulse_q <= any_multi | (we & dup);
    end
  end

  assign bus.tlb_multihit = mh_pulse_q;
`endif

  // TLBP / TLBR
  logic [IDX_W-1:0] r_idx;
  assign r_idx = bus.Index_in[IDX_W-1:0];

  always_comb begin
    bus.Index_out    = (|m_probe) ? 32'(or_encode(m_probe)) : 32'h8000_0000;
`ifdef TLB_MULTIHIT_EN
    bus.Index_out[30] = mh_sticky_q;
`endif
    bus.EntryHi_out  = {vpn2_q[r_idx], 13'(asid_q[r_idx])};
    bus.PageMask_out = {mask_q[r_idx], 13'b0};
    bus.EntryLo0_out = 32'({pfn0_q[r_idx], c0_q[r_idx], d0_q[r_idx], v0_q[r_idx], g_q[r_idx]});
    bus.EntryLo1_out = 32'({pfn1_q[r_idx], c1_q[r_idx], d1_q[r_idx], v1_q[r_idx], g_q[r_idx]});
  end

  logic unused_bits;
  assign unused_bits = ^{bus.TLBP, bus.TLBR, bus.Index_in[31:IDX_W], bus.wired_in[31:IDX_W],
                         bus.PageMask_in[12:0], bus.EntryHi_in[12:ASID_W],
                         bus.EntryLo0_in[31:PFN_W+6], bus.EntryLo1_in[31:PFN_W+6],
                         bus.inst_vaddr[11:0], bus.data_vaddr[11:0],
                         i_vpn_q[19:PFN_W-3], d_vpn_q[19:PFN_W-3]};
endmodule

// File: tb/tb_tlb_param.sv
// Self-checking bench for tlb_param: directed scenarios plus randomized lookups
// checked against an entry-table reference model.
module tb_tlb_param;
  localparam int ENTRIES = 16;
  localparam int ASID_W  = 8;
  localparam int PFN_W   = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlb_param_if #(.PFN_W(PFN_W)) bus ();
  tlb_param #(.ENTRIES(ENTRIES), .ASID_W(ASID_W), .PFN_W(PFN_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit        valid;
    bit [18:0] vpn2;
    bit [18:0] mask;
    bit [7:0]  asid;
    bit        g;
    bit [19:0] pfn0, pfn1;
    bit [2:0]  c0, c1;
    bit        d0, d1, v0, v1;
  } ent_t;

  typedef struct {
    bit [19:0] pfn;
    bit        hit, nc, refill, invalid, modify;
  } exp_t;

  ent_t        m_ent [ENTRIES];
  int unsigned m_rand, m_wired;
  int unsigned n_assert, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: reference model advances with the pre-edge inputs.
  task automatic tick();
    bit          do_w, rst_s, wwe_s, stall_s;
    int unsigned tgt, wi_s;
    ent_t        ne;
    rst_s   = rst;
    wwe_s   = bus.wired_we;
    stall_s = bus.stallM;
    wi_s    = bus.wired_in % ENTRIES;
    do_w    = bus.TLBWI || bus.TLBWR;
    tgt     = bus.TLBWI ? (bus.Index_in % ENTRIES) : m_rand;
    ne.valid = 1'b1;
    ne.mask  = bus.PageMask_in[31:13];
    ne.vpn2  = bus.EntryHi_in[31:13] & ~ne.mask;
    ne.asid  = bus.EntryHi_in[7:0];
    ne.g     = bus.EntryLo0_in[0] & bus.EntryLo1_in[0];
    ne.pfn0  = bus.EntryLo0_in[25:6] & ~{ne.mask, 1'b0};
    ne.pfn1  = bus.EntryLo1_in[25:6] & ~{ne.mask, 1'b0};
    ne.c0 = bus.EntryLo0_in[5:3]; ne.c1 = bus.EntryLo1_in[5:3];
    ne.d0 = bus.EntryLo0_in[2];   ne.d1 = bus.EntryLo1_in[2];
    ne.v0 = bus.EntryLo0_in[1];   ne.v1 = bus.EntryLo1_in[1];
    @(posedge clk);
    #1;
    if (rst_s) begin
      for (int i = 0; i < ENTRIES; i++) m_ent[i].valid = 1'b0;
      m_rand  = ENTRIES - 1;
      m_wired = 0;
    end else begin
      if (do_w) m_ent[tgt] = ne;
      if (wwe_s) begin
        m_wired = wi_s;
        m_rand  = ENTRIES - 1;
      end else if (!stall_s) begin
        m_rand = (m_rand == m_wired) ? ENTRIES - 1 : m_rand - 1;
      end
    end
  endtask

  function automatic exp_t lookup(input logic [31:0] va, input logic [7:0] asid,
                                  input bit acc, input bit wr);
    exp_t e;
    int   k;
    bit   c_nc, v, d;
    e = '{default: '0};
    if (va[31:30] == 2'b10) begin
      e.hit = 1'b1;
      e.pfn = {3'b000, va[28:12]};
      e.nc  = (va[31:29] == 3'b101);
      return e;
    end
    k = -1;
    for (int i = 0; i < ENTRIES; i++)
      if (m_ent[i].valid && (((va[31:13] ^ m_ent[i].vpn2) & ~m_ent[i].mask) == 0) &&
          (m_ent[i].g || m_ent[i].asid == asid))
        k = i;
    if (k < 0) begin
      e.refill = acc;
      return e;
    end
    e.hit = 1'b1;
    e.pfn = va[12] ? m_ent[k].pfn1 : m_ent[k].pfn0;
    c_nc  = va[12] ? (m_ent[k].c1 == 3'd2) : (m_ent[k].c0 == 3'd2);
    v     = va[12] ? m_ent[k].v1 : m_ent[k].v0;
    d     = va[12] ? m_ent[k].d1 : m_ent[k].d0;
    e.nc      = c_nc;
    e.invalid = acc && !v;
    e.modify  = wr && v && !d;
    return e;
  endfunction

  // Presents a fetch and/or data address, clocks once, checks the registered view.
  task automatic access(input string tag, input logic [31:0] iva, input logic [31:0] dva,
                        input logic [7:0] asid, input bit ien, input bit rd, input bit wr);
    exp_t ei, ed;
    ei = lookup(iva, asid, 1'b1, 1'b0);
    ed = lookup(dva, asid, rd | wr, wr);
    bus.inst_vaddr    = iva;
    bus.inst_en       = ien;
    bus.data_vaddr    = dva;
    bus.mem_read_enM  = rd;
    bus.mem_write_enM = wr;
    bus.EntryHi_in    = {24'h0, asid};
    tick();
    if (ien) begin
      if (ei.hit) begin
        chk({tag, ".ipfn"}, 32'(bus.inst_pfn), 32'(ei.pfn));
        chk({tag, ".inc"},  32'(bus.no_cache_i), 32'(ei.nc));
      end
      chk({tag, ".irefill"},  32'(bus.inst_tlb_refill),  32'(ei.refill));
      chk({tag, ".iinvalid"}, 32'(bus.inst_tlb_invalid), 32'(ei.invalid));
    end
    if (ed.hit) begin
      chk({tag, ".dpfn"}, 32'(bus.data_pfn), 32'(ed.pfn));
      chk({tag, ".dnc"},  32'(bus.no_cache_d), 32'(ed.nc));
    end
    chk({tag, ".drefill"},  32'(bus.data_tlb_refill),  32'(ed.refill));
    chk({tag, ".dinvalid"}, 32'(bus.data_tlb_invalid), 32'(ed.invalid));
    chk({tag, ".dmodify"},  32'(bus.data_tlb_modify),  32'(ed.modify));
  endtask

  task automatic tlb_write(input bit wi, input bit wr, input logic [31:0] idx,
                           input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    bus.TLBWI = wi; bus.TLBWR = wr;
    bus.Index_in = idx; bus.EntryHi_in = hi; bus.PageMask_in = 32'h0;
    bus.EntryLo0_in = lo0; bus.EntryLo1_in = lo1;
    tick();
    bus.TLBWI = 1'b0; bus.TLBWR = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] hi, input logic [31:0] exp);
    bus.TLBP = 1'b1; bus.EntryHi_in = hi;
    #1;
    chk(tag, bus.Index_out, exp);
    bus.TLBP = 1'b0;
  endtask

  task automatic tlbr(input string tag, input int unsigned idx);
    ent_t e;
    e = m_ent[idx];
    bus.TLBR = 1'b1; bus.Index_in = 32'(idx);
    #1;
    if (e.valid) begin
      chk({tag, ".hi"},  bus.EntryHi_out,  {e.vpn2, 5'b0, e.asid});
      chk({tag, ".pm"},  bus.PageMask_out, {e.mask, 13'b0});
      chk({tag, ".lo0"}, bus.EntryLo0_out, {6'b0, e.pfn0, e.c0, e.d0, e.v0, e.g});
      chk({tag, ".lo1"}, bus.EntryLo1_out, {6'b0, e.pfn1, e.c1, e.d1, e.v1, e.g});
    end
    bus.TLBR = 1'b0;
  endtask

  initial begin
    int unsigned r, r2, ia, idd, kind;
    logic [31:0] iva, dva, hi, lo0, lo1;
    n_assert = 0; n_fail = 0;
    m_rand = ENTRIES - 1; m_wired = 0;
    for (int i = 0; i < ENTRIES; i++) m_ent[i] = '{default: '0};
    rst = 1'b1;
    bus.stallF = 0; bus.stallM = 0; bus.flushM = 0;
    bus.inst_vaddr = 0; bus.inst_en = 0; bus.data_vaddr = 0;
    bus.mem_read_enM = 0; bus.mem_write_enM = 0;
    bus.TLBP = 0; bus.TLBR = 0; bus.TLBWI = 0; bus.TLBWR = 0;
    bus.EntryHi_in = 0; bus.PageMask_in = 0; bus.EntryLo0_in = 0; bus.EntryLo1_in = 0;
    bus.Index_in = 0; bus.wired_in = 0; bus.wired_we = 0;
    tick(); tick();
    rst = 1'b0;

    chk("rst.random", bus.Random_out, 32'd15);
    chk("rst.wired",  bus.Wired_out,  32'd0);
    probe("rst.probe", 32'h0000_0000, 32'h8000_0000);

    access("refill0", 32'h0, 32'h0000_0000, 8'd0, 1'b0, 1'b1, 1'b0);
    chk("refill0.lit", 32'(bus.data_tlb_refill), 32'd1);

    // PFN 0x123, C=3, D=1, V=1 on the even page; odd page invalid
    tlb_write(1, 0, 32'd3, 32'h0040_0001, 32'h0000_48DE, 32'h0);
    access("ld_even", 32'h0, 32'h0040_0010, 8'd1, 1'b0, 1'b1, 1'b0);
    chk("ld_even.lit", 32'(bus.data_pfn), 32'h123);
    access("ld_odd", 32'h0, 32'h0040_1000, 8'd1, 1'b0, 1'b1, 1'b0);
    chk("ld_odd.lit", 32'(bus.data_tlb_invalid), 32'd1);

    tlb_write(1, 0, 32'd3, 32'h0040_0001, 32'h0000_48DA, 32'h0);
    access("st_mod", 32'h0, 32'h0040_0000, 8'd1, 1'b0, 1'b0, 1'b1);
    chk("st_mod.lit", 32'(bus.data_tlb_modify), 32'd1);
    bus.flushM = 1'b1;
    tick();
    bus.flushM = 1'b0;
    chk("flush.refill",  32'(bus.data_tlb_refill),  32'd0);
    chk("flush.invalid", 32'(bus.data_tlb_invalid), 32'd0);
    chk("flush.modify",  32'(bus.data_tlb_modify),  32'd0);
    bus.mem_write_enM = 1'b0;

    probe("tlbp.hit",  32'h0040_0001, 32'd3);
    probe("tlbp.miss", 32'h0040_0002, 32'h8000_0000);
    tlbr("tlbr3", 3);
    chk("tlbr3.lit", bus.EntryLo0_out, 32'h0000_48DA);

    bus.wired_in = 32'd4; bus.wired_we = 1'b1;
    tick();
    bus.wired_we = 1'b0;
    chk("wired.val", bus.Wired_out, 32'd4);
    chk("wired.rand", bus.Random_out, 32'd15);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("rand.seq", bus.Random_out, 32'(m_rand));
    end
    bus.stallM = 1'b1;
    r = m_rand;
    repeat (2) begin
      tick();
      chk("rand.stall", bus.Random_out, 32'(r));
    end
    bus.stallM = 1'b0;

    // PFN 0x456, C=2 (uncached), D=1, V=1, ASID 2 via Random
    r = m_rand;
    tlb_write(0, 1, 32'd0, 32'h0080_0002, 32'h0001_1596, 32'h0);
    tlbr("tlbwr", r);
    chk("tlbwr.hi", bus.EntryHi_out, 32'h0080_0002);
    probe("tlbwr.probe", 32'h0080_0002, 32'(r));
    access("ld_wr", 32'h0, 32'h0080_0000, 8'd2, 1'b0, 1'b1, 1'b0);
    chk("ld_wr.nc", 32'(bus.no_cache_d), 32'd1);

    if (m_rand == 5) tick();
    r2 = m_rand;
    tlb_write(1, 1, 32'd5, 32'h00C0_0003, 32'h0000_1016, 32'h0);
    probe("both.probe", 32'h00C0_0003, 32'd5);
    tlbr("both5", 5);
    tlbr("both_r", r2);

    access("kseg1", 32'hBFC0_0000, 32'h0, 8'd1, 1'b1, 1'b0, 1'b0);
    chk("kseg1.lit", 32'(bus.inst_pfn), 32'h1FC00);
    bus.stallF = 1'b1;
    bus.inst_vaddr = 32'h0040_1000;
    repeat (3) begin
      tick();
      chk("stallF.pfn", 32'(bus.inst_pfn), 32'h1FC00);
      chk("stallF.nc",  32'(bus.no_cache_i), 32'd1);
      chk("stallF.inv", 32'(bus.inst_tlb_invalid), 32'd0);
    end
    bus.stallF = 1'b0;
    access("fetch_map", 32'h0040_0000, 32'h0, 8'd1, 1'b1, 1'b0, 1'b0);
    access("fetch_odd", 32'h0040_1000, 32'h0, 8'd1, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        ia  = $urandom_range(0, ENTRIES - 1);
        hi  = {19'(32'h100 + ia), 5'b0, 8'($urandom_range(1, 3))};
        lo0 = {6'b0, 20'($urandom), 3'($urandom), 3'($urandom)};
        lo1 = {6'b0, 20'($urandom), 3'($urandom), 3'($urandom)};
        tlb_write(1, 0, 32'(ia), hi, lo0, lo1);
      end else begin
        ia   = $urandom_range(0, ENTRIES - 1);
        idd  = $urandom_range(0, ENTRIES - 1);
        kind = $urandom_range(0, 4);
        iva  = {19'(32'h100 + ia), 13'($urandom)};
        dva  = (kind == 0) ? {2'b10, 30'($urandom)} :
               (kind == 1) ? {19'(32'h300 + idd), 13'($urandom)} :
                             {19'(32'h100 + idd), 13'($urandom)};
        kind = $urandom_range(0, 2);
        access("rnd", iva, dva, 8'($urandom_range(1, 3)), 1'b1, kind == 1, kind == 2);
      end
    end
    for (int i = 0; i < ENTRIES; i++) tlbr("sweep", i);

    bus.wired_in = 32'd15; bus.wired_we = 1'b1;
    tick();
    bus.wired_we = 1'b0;
    repeat (3) begin
      tick();
      chk("pin.rand", bus.Random_out, 32'd15);
    end

    rst = 1'b1;
    tick();
    rst = 1'b0;
    probe("rst2.probe", 32'h0040_0001, 32'h8000_0000);
    chk("rst2.wired", bus.Wired_out, 32'd0);
    chk("rst2.rand",  bus.Random_out, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tlb_param.md
Name: tlb_param

Overview:
- Parametrised joint TLB for the PipelineMIPS core. Entry count, ASID width and PFN width are parameters.
- Provides an instruction lookup port and a data lookup port. Each port has a one-stage result register.
- Executes TLBP, TLBR, TLBWI and TLBWR.
- Owns the CP0 Random/Wired replacement logic and a per-entry valid bit. Entries therefore never match after reset until they are written.
- Sits between the fetch/memory stages and the i/d caches, and supplies PFN, uncached flag and TLB exceptions.

Parameters:
- ENTRIES, 16, number of TLB entries; power of two, 4..64.
- IDX_W, log2(ENTRIES), index width; derived, not overridden.
- ASID_W, 8, ASID field width.
- PFN_W, 20, physical page number width. Pages are 4 KB, so the offset is 12 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stallF  in  1  hold instruction-port result register
- stallM, flushM  in  1 each  hold / clear data-port result register
- inst_vaddr  in  32  fetch virtual address
- inst_en  in  1  fetch valid
- data_vaddr  in  32  E-stage data virtual address
- mem_read_enM, mem_write_enM  in  1 each  M-stage access type
- inst_pfn, data_pfn  out  PFN_W  translated PFN (registered-stage view)
- no_cache_i, no_cache_d  out  1 each  uncached access
- inst_tlb_refill, inst_tlb_invalid  out  1 each  fetch TLB exceptions
- data_tlb_refill, data_tlb_invalid, data_tlb_modify  out  1 each  data TLB exceptions
- TLBP, TLBR, TLBWI, TLBWR  in  1 each  M-stage TLB ops, one-hot or zero
- EntryHi_in, PageMask_in, EntryLo0_in, EntryLo1_in, Index_in  in  32 each  CP0 values
- wired_in  in  32  new Wired value
- wired_we  in  1  write Wired
- EntryHi_out, PageMask_out, EntryLo0_out, EntryLo1_out, Index_out  out  32 each  TLBR/TLBP results
- Random_out, Wired_out  out  32 each  CP0 Random/Wired read values (zero-extended)

Behaviour:
- Match on entry i requires all of:
  - valid[i];
  - (va[31:13] & ~mask[i]) == (vpn2[i] & ~mask[i]);
  - G[i] or ASID[i] == EntryHi_in ASID.
- Hit index is an OR-encode of the match vector.

Instruction port:
- Registers hit, index, odd bit va[12], kseg01 and kseg1 flags, and VPN.
- Register loads when ~stallF; clears on rst only.

Data port:
- Same register contents as the instruction port.
- Loads when ~stallM; clears on rst or flushM. flushM has priority over ~stallM.
- Latency is 1 cycle for both ports: address presented in cycle N gives results valid in cycle N+1.

Translation and uncached:
- kseg0/1 (va[31:30]==2'b10) is unmapped: pfn = {3'b0, vpn[PFN_W-4:0]}, and no exceptions are raised.
- no_cache = kseg1 (va[31:29]==3'b101) for unmapped addresses; otherwise no_cache = (C==3'b010).
- Mapped addresses select EntryLo0 when odd==0, EntryLo1 when odd==1.

Exceptions (mapped addresses only):
- refill = access & ~hit.
- invalid = access & hit & ~V.
- modify = write & hit & V & ~D.
- For the instruction port, access = inst_en. For the data port, access = read | write.

TLBP:
- Combinational against EntryHi_in.
- Index_out = {27'b0, idx} on hit, 32'h8000_0000 on miss.

TLBR:
- Reads entry Index_in[IDX_W-1:0] combinationally.
- EntryLo0_out[0] and EntryLo1_out[0] both return G.

TLBWI / TLBWR writes:
- On the clock edge, write vpn2 & ~mask, G = Lo0.G & Lo1.G, ASID, mask, PFN & ~mask, C, D, V, and set valid.
- TLBWI uses Index_in; TLBWR uses the internal Random.
- If both TLBWI and TLBWR are asserted, TLBWI wins.
- A lookup in the same cycle as a write sees the old contents.

Random and Wired:
- Reset: Random = ENTRIES-1, Wired = 0, all valid = 0.
- Each cycle: if Random == Wired, Random becomes ENTRIES-1; otherwise Random decrements.
- wired_we: Wired <= wired_in[IDX_W-1:0] and Random <= ENTRIES-1. This has priority over the decrement.
- Wired >= ENTRIES-1 pins Random at ENTRIES-1.
- Random holds while stallM is asserted.

Other rules:
- Index bits above IDX_W are ignored.
- rst during any operation clears all registers and valid bits in the same edge.

Optional Feature:
- Macro: TLB_MULTIHIT_EN.
- When defined, a popcount > 1 on any match vector sets:
  - a sticky internal flag, readable as Index_out[30] on TLBP;
  - a one-cycle output pulse tlb_multihit.
- When defined, a TLBWI/TLBWR whose new entry would duplicate another valid entry's vpn2/ASID still writes, but pulses tlb_multihit.
- When undefined, the tlb_multihit port is absent, Index_out[30] reads 0, and multiple hits OR their indices (unspecified result).

Test Plan:
- Reset, then data_vaddr=0x00000000 with a read: next cycle data_tlb_refill=1 (no valid entries).
- TLBWI Index=3, EntryHi=0x00400001, Lo0 = PFN 0x123 with C=3, D=1, V=1, Lo1.V=0, ASID 1; then load at 0x00400010 → data_pfn=0x123, no_cache_d=0, no exception; load at 0x00401000 → data_tlb_invalid=1.
- Same entry with Lo0.D=0, store at 0x00400000 → data_tlb_modify=1. Then apply flushM in the following cycle → all data exception outputs 0.
- TLBP with EntryHi=0x00400001 → Index_out=3; with EntryHi=0x00400002 (ASID mismatch, G=0) → Index_out=0x80000000.
- wired_we with wired_in=4, ENTRIES=16 → Random sequence 15,14,…,4,15,…; TLBWR writes the entry currently at Random; TLBWI and TLBWR asserted together → Index_in entry written.
- fetch at 0xBFC00000 → inst_pfn=0x1FC00, no_cache_i=1, no exceptions; stallF held for 3 cycles → outputs frozen.
